// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PHASE_WAIT = 2'd1,
        RUN        = 2'd2
    } ch_state_t;

    // Smallest divide ratio that still yields a real high and low phase.
    localparam int unsigned DIV_MIN = 2;

    // High-phase length: ceil(D/2), so odd ratios get the extra cycle high.
    function automatic int unsigned half_up(input int unsigned d);
        return (d + 1) >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_ch.sv
// One divider channel: load/phase-wait/run FSM with fully registered outputs.
module clkdiv_ch
    import clkdiv_pkg::*;
#(
    parameter int DIV_W = 8
)
(
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             ch_en,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic [DIV_W-1:0] phase_cfg,
    input  logic             sync,
    output logic             oclk,
    output logic             tick,
    output logic             active,
    output logic             cfg_err
);

    ch_state_t        state, state_d;
    logic [DIV_W-1:0] cnt, cnt_d;
    logic [DIV_W-1:0] dlat, dlat_d;
    logic [DIV_W-1:0] plat, plat_d;
    logic             err_d, oclk_d, tick_d, active_d;
    logic             cfg_ok;

    assign cfg_ok = 32'(div_cfg) >= DIV_MIN;

    // Next-state logic; outputs are derived from the next state/count so that
    // the registered oclk already reflects the count it will accompany.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        dlat_d  = dlat;
        plat_d  = plat;
        err_d   = cfg_err;
        if (sync || state == IDLE) begin
            // sync treats every channel as freshly idle, truncating if needed
            cnt_d = '0;
            if (ch_en && cfg_ok) begin
                dlat_d  = div_cfg;
                plat_d  = phase_cfg;
                err_d   = 1'b0;
                state_d = (phase_cfg == '0) ? RUN : PHASE_WAIT;
            end else begin
                state_d = IDLE;
                if (ch_en) begin
                    err_d = 1'b1;
                end
            end
        end else if (state == PHASE_WAIT) begin
            if (cnt == plat - DIV_W'(1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt + DIV_W'(1);
            end
        end else begin
            if (cnt == dlat - DIV_W'(1)) begin
                // period boundary: the only place enable/ratio changes land
                cnt_d = '0;
                if (!ch_en) begin
                    state_d = IDLE;
                end else if (cfg_ok) begin
                    dlat_d = div_cfg;
                    err_d  = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                cnt_d = cnt + DIV_W'(1);
            end
        end
        oclk_d   = (state_d == RUN) && (32'(cnt_d) < half_up(32'(dlat_d)));
        tick_d   = oclk_d && (cnt_d == '0);
        active_d = (state_d != IDLE);
    end

    // State, counter, latched config and all outputs register on iclk.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            dlat    <= '0;
            plat    <= '0;
            cfg_err <= 1'b0;
            oclk    <= 1'b0;
            tick    <= 1'b0;
            active  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            dlat    <= dlat_d;
            plat    <= plat_d;
            cfg_err <= err_d;
            oclk    <= oclk_d;
            tick    <= tick_d;
            active  <= active_d;
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// N_CH independent divided clocks from iclk, sharing reset and a common sync.
module clkdiv_multi #(
    parameter int N_CH  = 4,
    parameter int DIV_W = 8
)
(
    input  logic                  iclk,
    input  logic                  irst_n,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH*DIV_W-1:0] div_cfg,
    input  logic [N_CH*DIV_W-1:0] phase_cfg,
    input  logic                  sync,
    output logic [N_CH-1:0]       oclk,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       active,
    output logic [N_CH-1:0]       cfg_err
);

    for (genvar n = 0; n < N_CH; n++) begin : g_ch
        clkdiv_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .iclk      (iclk),
            .irst_n    (irst_n),
            .ch_en     (ch_en[n]),
            .div_cfg   (div_cfg[n*DIV_W +: DIV_W]),
            .phase_cfg (phase_cfg[n*DIV_W +: DIV_W]),
            .sync      (sync),
            .oclk      (oclk[n]),
            .tick      (tick[n]),
            .active    (active[n]),
            .cfg_err   (cfg_err[n])
        );
    end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Parametrised multi-channel clock generator; successor to the single-channel clock buffer.
- Derives N_CH divided clocks from iclk. Each channel has a programmable divide ratio, a start-phase offset and an enable.
- Shutdown and ratio changes are glitch-free; a common sync input re-aligns all channels.
- Outputs feed the clock-enable and clock-monitor logic downstream. Every output is a register; none is combinational.

Parameters:
- N_CH, 4: number of independent output channels.
- DIV_W, 8: width of each channel's divide ratio and phase fields.

Ports:
- iclk  in  1  source clock; all logic on its rising edge.
- irst_n  in  1  asynchronous, active-low reset.
- ch_en  in  N_CH  per-channel run enable.
- div_cfg  in  N_CH*DIV_W  divide ratio D per channel; channel n uses bits [n*DIV_W +: DIV_W].
- phase_cfg  in  N_CH*DIV_W  start delay P per channel, in iclk cycles; same slicing as div_cfg.
- sync  in  1  one-cycle pulse; restarts all enabled channels together.
- oclk  out  N_CH  divided clock outputs.
- tick  out  N_CH  one-cycle pulse, high in the first high cycle of each oclk period.
- active  out  N_CH  channel is in PHASE_WAIT or RUN.
- cfg_err  out  N_CH  last load attempt on the channel saw D<2.

Behaviour:
- Reset (irst_n=0, asynchronous): all channels go to IDLE. oclk=0, tick=0, active=0, cfg_err=0, counters=0, latched D and P =0. Reset mid-period truncates immediately; this is the only source of an unclean edge besides sync.
- Per-channel FSM states: IDLE, PHASE_WAIT, RUN. One counter cnt of DIV_W bits.
- H = ceil(D/2), computed on the latched D. oclk is high while cnt<H.
- IDLE: oclk=0, active=0.
  - On edge k with ch_en=1 and D>=2: latch D and P, set cfg_err=0, cnt=0.
  - Next state is RUN if P=0, otherwise PHASE_WAIT.
  - If ch_en=1 and D<2: stay in IDLE and set cfg_err=1.
- PHASE_WAIT: cnt counts 0..P-1; oclk=0. At cnt=P-1, go to RUN with cnt=0.
- Start timing: oclk rises on edge k+P, where k is the first edge that samples the load condition.
- RUN: cnt counts 0..D-1 and wraps.
  - oclk is registered so that it is 1 when the next cnt<H. This gives H cycles high and D-H cycles low; duty is 50% for even D, and the high phase is one cycle longer for odd D.
  - tick=1 exactly in the cycle where cnt=0 and oclk=1.
- Period end (cnt=D-1, oclk already low):
  - ch_en=0: go to IDLE; oclk stays low.
  - ch_en=1 and new div_cfg>=2: reload D, clear cfg_err, continue in RUN at cnt=0. P is not re-applied.
  - ch_en=1 and new div_cfg<2: keep the old D, set cfg_err=1, continue.
- Mid-period config handling:
  - div_cfg and phase_cfg changes mid-period are ignored until period end or sync.
  - ch_en deasserting mid-period completes the current period first.
- sync=1 at an edge (priority over period end and over all other transitions), every channel is handled as if it were in IDLE at that edge:
  - ch_en=1 and D>=2: reload D and P and restart.
  - ch_en=1 and D<2: go to IDLE with cfg_err=1.
  - ch_en=0: go to IDLE.
  - oclk may be truncated at this edge; this is permitted only on sync.
- Channels are fully independent apart from iclk, irst_n and sync.

Decomposition:
- Package clkdiv_pkg holds:
  - the state enum {IDLE, PHASE_WAIT, RUN};
  - the constant DIV_MIN=2;
  - a function computing ceil(D/2).
- Sub-module clkdiv_ch: one channel (FSM, counter, registered oclk/tick/active/cfg_err). clkdiv_multi instantiates it N_CH times in a generate loop and slices the config buses.

Test Plan:
- D=4, P=0, ch_en rises before edge k -> oclk high on edges k..k+1 and low on k+2..k+3; period 4; tick at k, k+4, k+8; active=1 from k.
- D=5 -> oclk high 3 cycles, low 2 cycles, repeating; tick every 5 cycles.
- ch0 D=4 P=0 and ch1 D=4 P=1, enabled on the same edge -> ch1 oclk lags ch0 by exactly 1 cycle; ch1 active=1 during its wait cycle.
- Running at D=4, div_cfg changed to 6 mid-period -> current period stays 4 cycles, next periods are 6 cycles (3 high/3 low), no runt pulse.
- Failed loads:
  - IDLE with ch_en=1 and D=1 -> cfg_err=1, oclk=0, active=0.
  - Running at D=4, div_cfg changed to 0 -> D stays 4, cfg_err=1 at the period end.
- Shutdown and sync:
  - ch_en drops mid-high -> period completes, then active=0, oclk=0.
  - sync pulse mid-run with D=4 P=2 -> oclk low for 2 cycles, then rises.
  - irst_n low mid-run -> all outputs 0 immediately.
